updown_mod_counter: RTL and testbench

Parametrised synchronous modulo counter built from a bank of T flip-flops. Adds up, down, hold and ping-pong modes, a priority parallel load, a cascade terminal-count output and a wrap flag. Used behind board push-button clocks or free-running clocks, feeding the binary-to-BCD display path or the `en` of a further counter stage.

---
 rtl/counter_pkg.sv | 12 +
 rtl/t_ff_cell.sv | 21 ++
 rtl/updown_mod_counter.sv | 141 ++++++++++++++
 tb/tb_updown_mod_counter.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared mode and direction encodings for the up/down modulo counter family.
package counter_pkg;

    localparam logic [1:0] MODE_HOLD     = 2'b00;
    localparam logic [1:0] MODE_UP       = 2'b01;
    localparam logic [1:0] MODE_DOWN     = 2'b10;
    localparam logic [1:0] MODE_PINGPONG = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/t_ff_cell.sv
// Single T flip-flop storage bit with synchronous active-low reset.
module t_ff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo counter with up/down/hold/ping-pong modes built from a bank of T flip-flops.
// Next state is decoded here and turned into a toggle vector for the cells.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load_n,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             dir,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   ONE_EXT = (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_loadVal;
    logic [WIDTH:0]   w_qExt;
    logic [WIDTH:0]   w_incr;
    logic [WIDTH:0]   w_decr;
    logic             w_atTop;
    logic             w_atBottom;
    logic             w_step;
    logic             w_nextDir;
    logic             w_nextWrap;
    logic             w_tcSel;
    logic             r_dir;
    logic             r_wrap;

    // One extra bit keeps q+1 exact at MODULUS=2**WIDTH; the borrow bit of q-1 flags q==0.
    assign w_qExt     = {1'b0, w_q};
    assign w_incr     = w_qExt + ONE_EXT;
    assign w_decr     = w_qExt - ONE_EXT;
    assign w_atTop    = (w_incr == MOD_EXT);
    assign w_atBottom = w_decr[WIDTH];
    assign w_loadVal  = ({1'b0, d} >= MOD_EXT) ? MAX_Q : d;
    assign w_step     = en && (mode != MODE_HOLD);

    always_comb begin
        w_next     = w_q;
        w_nextDir  = r_dir;
        w_nextWrap = 1'b0;
        if (!rst_n) begin
            w_next    = '0;
            w_nextDir = DIR_UP;
        end else if (!load_n) begin
            w_next    = w_loadVal;
            w_nextDir = DIR_UP;
        end else if (w_step) begin
            case (mode)
                MODE_UP: begin
                    if (w_atTop) begin
                        w_next     = '0;
                        w_nextWrap = 1'b1;
                    end else begin
                        w_next = w_incr[WIDTH-1:0];
                    end
                end
                MODE_DOWN: begin
                    if (w_atBottom) begin
                        w_next     = MAX_Q;
                        w_nextWrap = 1'b1;
                    end else begin
                        w_next = w_decr[WIDTH-1:0];
                    end
                end
                MODE_PINGPONG: begin
                    // An endpoint is held for one step only: the step leaving it turns around.
                    if (r_dir == DIR_UP) begin
                        if (w_atTop) begin
                            w_next     = w_decr[WIDTH-1:0];
                            w_nextDir  = DIR_DOWN;
                            w_nextWrap = 1'b1;
                        end else begin
                            w_next = w_incr[WIDTH-1:0];
                        end
                    end else begin
                        if (w_atBottom) begin
                            w_next     = w_incr[WIDTH-1:0];
                            w_nextDir  = DIR_UP;
                            w_nextWrap = 1'b1;
                        end else begin
                            w_next = w_decr[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    w_next = w_q;
                end
            endcase
        end
    end

    assign w_t = w_q ^ w_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (w_t[i]),
            .q     (w_q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dir  <= DIR_UP;
            r_wrap <= 1'b0;
        end else begin
            r_dir  <= w_nextDir;
            r_wrap <= w_nextWrap;
        end
    end

    always_comb begin
        w_tcSel = 1'b0;
        case (mode)
            MODE_UP:       w_tcSel = w_atTop;
            MODE_DOWN:     w_tcSel = w_atBottom;
            MODE_PINGPONG: w_tcSel = (r_dir == DIR_UP) ? w_atTop : w_atBottom;
            default:       w_tcSel = 1'b0;
        endcase
    end

    assign tc   = rst_n & load_n & en & w_tcSel;
    assign q    = w_q;
    assign dir  = r_dir;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter: several parameterisations share one set of controls,
// expectations are queued as stimulus is driven and compared one cycle later.
module tb_updown_mod_counter;
    import counter_pkg::*;

    localparam int S10   = 0;
    localparam int S4    = 1;
    localparam int S2    = 2;
    localparam int SFULL = 3;
    localparam int SC0   = 4;
    localparam int SC1   = 5;

    typedef struct {
        int    sel;
        string tag;
        int    q;
        logic  dir;
        logic  wrap;
    } exp_t;

    typedef struct {
        logic [31:0] q;
        logic        dir;
        logic        wrap;
        logic        tc;
    } obs_t;

    logic       clock = 1'b0;
    logic       rstN;
    logic       en;
    logic       loadN;
    logic [1:0] mode;
    logic [3:0] d10;
    logic [1:0] d4;
    logic [1:0] d2;
    logic [7:0] dFull;
    logic [3:0] dCas;

    logic [3:0] q10;
    logic [1:0] q4;
    logic [1:0] q2;
    logic [7:0] qFull;
    logic [3:0] qC0;
    logic [3:0] qC1;
    logic dir10, dir4, dir2, dirFull, dirC0, dirC1;
    logic tc10, tc4, tc2, tcFull, tcC0, tcC1;
    logic wrap10, wrap4, wrap2, wrapFull, wrapC0, wrapC1;

    exp_t sbQ[$];
    exp_t e;
    obs_t o;
    int   errors = 0;
    int   checks = 0;

    int   ppQ[9]    = '{1, 2, 3, 2, 1, 0, 1, 2, 3};
    bit   ppDir[9]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    bit   ppWrap[9] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
    bit   ppTc[9]   = '{0, 0, 0, 1, 0, 0, 1, 0, 0};

    logic [1:0] mcMode[6] = '{MODE_PINGPONG, MODE_UP, MODE_UP, MODE_PINGPONG, MODE_DOWN, MODE_DOWN};
    bit   mcTc[6]   = '{1, 0, 1, 1, 0, 1};
    int   mcQ[6]    = '{2, 3, 0, 1, 0, 3};
    bit   mcDir[6]  = '{1, 1, 1, 0, 0, 0};
    bit   mcWrap[6] = '{1, 0, 1, 1, 0, 1};

    logic [1:0] fwMode[5] = '{MODE_UP, MODE_UP, MODE_UP, MODE_DOWN, MODE_DOWN};
    bit   fwTc[5]   = '{0, 1, 0, 0, 1};
    int   fwQ[5]    = '{255, 0, 1, 0, 255};
    bit   fwWrap[5] = '{0, 1, 0, 0, 1};

    always #5 clock = ~clock;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk(clock), .rst_n(rstN), .en(en), .load_n(loadN), .d(d10), .mode(mode),
        .q(q10), .dir(dir10), .tc(tc10), .wrap(wrap10)
    );

    updown_mod_counter #(.WIDTH(2), .MODULUS(4)) dut4 (
        .clk(clock), .rst_n(rstN), .en(en), .load_n(loadN), .d(d4), .mode(mode),
        .q(q4), .dir(dir4), .tc(tc4), .wrap(wrap4)
    );

    updown_mod_counter #(.WIDTH(2), .MODULUS(2)) dut2 (
        .clk(clock), .rst_n(rstN), .en(en), .load_n(loadN), .d(d2), .mode(mode),
        .q(q2), .dir(dir2), .tc(tc2), .wrap(wrap2)
    );

    updown_mod_counter dutFull (
        .clk(clock), .rst_n(rstN), .en(en), .load_n(loadN), .d(dFull), .mode(mode),
        .q(qFull), .dir(dirFull), .tc(tcFull), .wrap(wrapFull)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10)) cas0 (
        .clk(clock), .rst_n(rstN), .en(en), .load_n(loadN), .d(dCas), .mode(mode),
        .q(qC0), .dir(dirC0), .tc(tcC0), .wrap(wrapC0)
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10)) cas1 (
        .clk(clock), .rst_n(rstN), .en(tcC0), .load_n(loadN), .d(dCas), .mode(mode),
        .q(qC1), .dir(dirC1), .tc(tcC1), .wrap(wrapC1)
    );

    function automatic obs_t observe(input int sel);
        obs_t r;
        case (sel)
            S10:     r = '{32'(q10), dir10, wrap10, tc10};
            S4:      r = '{32'(q4), dir4, wrap4, tc4};
            S2:      r = '{32'(q2), dir2, wrap2, tc2};
            SFULL:   r = '{32'(qFull), dirFull, wrapFull, tcFull};
            SC0:     r = '{32'(qC0), dirC0, wrapC0, tcC0};
            SC1:     r = '{32'(qC1), dirC1, wrapC1, tcC1};
            default: r = '{32'hFFFF_FFFF, 1'bx, 1'bx, 1'bx};
        endcase
        return r;
    endfunction

    function automatic void pushExp(input int sel, input string tag, input int q,
                                    input logic dir, input logic wrap);
        sbQ.push_back('{sel, tag, q, dir, wrap});
    endfunction

    task automatic test_reset();
        rstN  = 1'b0;
        en    = 1'b1;
        loadN = 1'b1;
        mode  = MODE_UP;
        for (int c = 0; c < 2; c++) begin
            #1;
            o = observe(S10);
            checks++;
            if (o.tc !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset tc: got %b expected 0", o.tc);
            end
            for (int s = 0; s < 6; s++) pushExp(s, $sformatf("reset.sel%0d", s), 0, 1'b0, 1'b0);
            @(posedge clock); #1;
            while (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                o = observe(e.sel);
                checks++;
                if (o.q !== 32'(e.q)) begin errors++; $display("[TB] FAIL %s q: got %0d expected %0d", e.tag, o.q, e.q); end
                checks++;
                if (o.dir !== e.dir) begin errors++; $display("[TB] FAIL %s dir: got %b expected %b", e.tag, o.dir, e.dir); end
                checks++;
                if (o.wrap !== e.wrap) begin errors++; $display("[TB] FAIL %s wrap: got %b expected %b", e.tag, o.wrap, e.wrap); end
            end
        end
    endtask

    task automatic test_up_wrap();
        int cur;
        rstN  = 1'b1;
        loadN = 1'b1;
        en    = 1'b1;
        mode  = MODE_UP;
        for (int i = 0; i < 11; i++) begin
            cur = i % 10;
            #1;
            o = observe(S10);
            checks++;
            if (o.tc !== (cur == 9)) begin
                errors++;
                $display("[TB] FAIL up_wrap tc at q=%0d: got %b expected %b", cur, o.tc, (cur == 9));
            end
            pushExp(S10, $sformatf("up_wrap.step%0d", i), (cur + 1) % 10, 1'b0, cur == 9);
            @(posedge clock); #1;
            while (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                o = observe(e.sel);
                checks++;
                if (o.q !== 32'(e.q)) begin errors++; $display("[TB] FAIL %s q: got %0d expected %0d", e.tag, o.q, e.q); end
                checks++;
                if (o.dir !== e.dir) begin errors++; $display("[TB] FAIL %s dir: got %b expected %b", e.tag, o.dir, e.dir); end
                checks++;
                if (o.wrap !== e.wrap) begin errors++; $display("[TB] FAIL %s wrap: got %b expected %b", e.tag, o.wrap, e.wrap); end
            end
        end
    endtask

    task automatic test_down_load();
        int cur;
        // Step 0 loads 3 with en low, steps 1..4 count down, step 5 loads an out-of-range 12.
        for (int i = 0; i < 6; i++) begin
            mode  = MODE_DOWN;
            cur   = 3 - (i - 1);
            loadN = (i == 0 || i == 5) ? 1'b0 : 1'b1;
            en    = (i == 0) ? 1'b0 : 1'b1;
            d10   = (i == 5) ? 4'd12 : 4'd3;
            #1;
            o = observe(S10);
            checks++;
            if (o.tc !== (loadN && cur == 0)) begin
                errors++;
                $display("[TB] FAIL down_load tc step%0d: got %b expected %b", i, o.tc, (loadN && cur == 0));
            end
            if (i == 0)      pushExp(S10, "down_load.load3", 3, 1'b0, 1'b0);
            else if (i == 5) pushExp(S10, "down_load.clamp12", 9, 1'b0, 1'b0);
            else             pushExp(S10, $sformatf("down_load.step%0d", i), (cur + 9) % 10, 1'b0, cur == 0);
            @(posedge clock); #1;
            while (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                o = observe(e.sel);
                checks++;
                if (o.q !== 32'(e.q)) begin errors++; $display("[TB] FAIL %s q: got %0d expected %0d", e.tag, o.q, e.q); end
                checks++;
                if (o.dir !== e.dir) begin errors++; $display("[TB] FAIL %s dir: got %b expected %b", e.tag, o.dir, e.dir); end
                checks++;
                if (o.wrap !== e.wrap) begin errors++; $display("[TB] FAIL %s wrap: got %b expected %b", e.tag, o.wrap, e.wrap); end
            end
        end
    endtask

    task automatic test_hold();
        logic expTc;
        loadN = 1'b1;
        // q sits at 9: hold twice, disable once, then one real wrapping step.
        for (int i = 0; i < 4; i++) begin
            mode  = (i < 2) ? MODE_HOLD : MODE_UP;
            en    = (i == 2) ? 1'b0 : 1'b1;
            expTc = (i == 3);
            #1;
            o = observe(S10);
            checks++;
            if (o.tc !== expTc) begin
                errors++;
                $display("[TB] FAIL hold tc step%0d: got %b expected %b", i, o.tc, expTc);
            end
            pushExp(S10, $sformatf("hold.step%0d", i), (i == 3) ? 0 : 9, 1'b0, i == 3);
            @(posedge clock); #1;
            while (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                o = observe(e.sel);
                checks++;
                if (o.q !== 32'(e.q)) begin errors++; $display("[TB] FAIL %s q: got %0d expected %0d", e.tag, o.q, e.q); end
                checks++;
                if (o.dir !== e.dir) begin errors++; $display("[TB] FAIL %s dir: got %b expected %b", e.tag, o.dir, e.dir); end
                checks++;
                if (o.wrap !== e.wrap) begin errors++; $display("[TB] FAIL %s wrap: got %b expected %b", e.tag, o.wrap, e.wrap); end
            end
        end
    endtask

    task automatic test_pingpong();
        logic expTc2;
        // Step 0 resets; steps 1..9 run ping-pong on the MODULUS=4 and MODULUS=2 counters.
        for (int i = 0; i < 10; i++) begin
            rstN  = (i == 0) ? 1'b0 : 1'b1;
            loadN = 1'b1;
            en    = 1'b1;
            mode  = MODE_PINGPONG;
            #1;
            if (i == 0) begin
                pushExp(S4, "pingpong.reset4", 0, 1'b0, 1'b0);
                pushExp(S2, "pingpong.reset2", 0, 1'b0, 1'b0);
            end else begin
                expTc2 = (i > 1);
                o = observe(S4);
                checks++;
                if (o.tc !== ppTc[i-1]) begin
                    errors++;
                    $display("[TB] FAIL pingpong4 tc step%0d: got %b expected %b", i - 1, o.tc, ppTc[i-1]);
                end
                o = observe(S2);
                checks++;
                if (o.tc !== expTc2) begin
                    errors++;
                    $display("[TB] FAIL pingpong2 tc step%0d: got %b expected %b", i - 1, o.tc, expTc2);
                end
                pushExp(S4, $sformatf("pingpong4.step%0d", i - 1), ppQ[i-1], ppDir[i-1], ppWrap[i-1]);
                pushExp(S2, $sformatf("pingpong2.step%0d", i - 1), i % 2, (i % 2) == 0, i > 1);
            end
            @(posedge clock); #1;
            while (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                o = observe(e.sel);
                checks++;
                if (o.q !== 32'(e.q)) begin errors++; $display("[TB] FAIL %s q: got %0d expected %0d", e.tag, o.q, e.q); end
                checks++;
                if (o.dir !== e.dir) begin errors++; $display("[TB] FAIL %s dir: got %b expected %b", e.tag, o.dir, e.dir); end
                checks++;
                if (o.wrap !== e.wrap) begin errors++; $display("[TB] FAIL %s wrap: got %b expected %b", e.tag, o.wrap, e.wrap); end
            end
        end
    endtask

    task automatic test_mode_change();
        // Continues from q=3, dir=up on the MODULUS=4 counter.
        for (int i = 0; i < 6; i++) begin
            mode = mcMode[i];
            en   = 1'b1;
            #1;
            o = observe(S4);
            checks++;
            if (o.tc !== mcTc[i]) begin
                errors++;
                $display("[TB] FAIL mode_change tc step%0d: got %b expected %b", i, o.tc, mcTc[i]);
            end
            pushExp(S4, $sformatf("mode_change.step%0d", i), mcQ[i], mcDir[i], mcWrap[i]);
            @(posedge clock); #1;
            while (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                o = observe(e.sel);
                checks++;
                if (o.q !== 32'(e.q)) begin errors++; $display("[TB] FAIL %s q: got %0d expected %0d", e.tag, o.q, e.q); end
                checks++;
                if (o.dir !== e.dir) begin errors++; $display("[TB] FAIL %s dir: got %b expected %b", e.tag, o.dir, e.dir); end
                checks++;
                if (o.wrap !== e.wrap) begin errors++; $display("[TB] FAIL %s wrap: got %b expected %b", e.tag, o.wrap, e.wrap); end
            end
        end
    endtask

    task automatic test_priority();
        // Load 5, then load 7 while enabled, then reset while loading.
        for (int i = 0; i < 3; i++) begin
            rstN  = (i == 2) ? 1'b0 : 1'b1;
            loadN = 1'b0;
            en    = (i == 0) ? 1'b0 : 1'b1;
            mode  = MODE_UP;
            d10   = (i == 0) ? 4'd5 : 4'd7;
            d4    = 2'd2;
            #1;
            o = observe(S10);
            checks++;
            if (o.tc !== 1'b0) begin
                errors++;
                $display("[TB] FAIL priority tc step%0d: got %b expected 0", i, o.tc);
            end
            pushExp(S10, $sformatf("priority10.step%0d", i), (i == 0) ? 5 : ((i == 1) ? 7 : 0), 1'b0, 1'b0);
            pushExp(S4, $sformatf("priority4.step%0d", i), (i == 2) ? 0 : 2, 1'b0, 1'b0);
            @(posedge clock); #1;
            while (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                o = observe(e.sel);
                checks++;
                if (o.q !== 32'(e.q)) begin errors++; $display("[TB] FAIL %s q: got %0d expected %0d", e.tag, o.q, e.q); end
                checks++;
                if (o.dir !== e.dir) begin errors++; $display("[TB] FAIL %s dir: got %b expected %b", e.tag, o.dir, e.dir); end
                checks++;
                if (o.wrap !== e.wrap) begin errors++; $display("[TB] FAIL %s wrap: got %b expected %b", e.tag, o.wrap, e.wrap); end
            end
        end
        rstN = 1'b1;
    endtask

    task automatic test_full_width();
        // Step 0 loads 254 into the 8-bit counter; then it crosses 255 both ways.
        for (int i = 0; i < 6; i++) begin
            rstN  = 1'b1;
            loadN = (i == 0) ? 1'b0 : 1'b1;
            en    = 1'b1;
            dFull = 8'd254;
            mode  = (i == 0) ? MODE_UP : fwMode[i-1];
            #1;
            o = observe(SFULL);
            checks++;
            if (o.tc !== ((i == 0) ? 1'b0 : fwTc[i-1])) begin
                errors++;
                $display("[TB] FAIL full_width tc step%0d: got %b expected %b", i, o.tc, (i == 0) ? 1'b0 : fwTc[i-1]);
            end
            if (i == 0) pushExp(SFULL, "full_width.load254", 254, 1'b0, 1'b0);
            else        pushExp(SFULL, $sformatf("full_width.step%0d", i), fwQ[i-1], 1'b0, fwWrap[i-1]);
            @(posedge clock); #1;
            while (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                o = observe(e.sel);
                checks++;
                if (o.q !== 32'(e.q)) begin errors++; $display("[TB] FAIL %s q: got %0d expected %0d", e.tag, o.q, e.q); end
                checks++;
                if (o.dir !== e.dir) begin errors++; $display("[TB] FAIL %s dir: got %b expected %b", e.tag, o.dir, e.dir); end
                checks++;
                if (o.wrap !== e.wrap) begin errors++; $display("[TB] FAIL %s wrap: got %b expected %b", e.tag, o.wrap, e.wrap); end
            end
        end
    endtask

    task automatic test_cascade();
        int cur0;
        int cur1;
        // Step 0 resets; steps 1..37 count enabled; steps 38..40 hold with en low.
        for (int i = 0; i < 41; i++) begin
            rstN  = (i == 0) ? 1'b0 : 1'b1;
            loadN = 1'b1;
            mode  = MODE_UP;
            en    = (i <= 37) ? 1'b1 : 1'b0;
            cur0  = (i <= 37) ? (i - 1) % 10 : 7;
            cur1  = (i <= 37) ? ((i - 1) / 10) % 10 : 3;
            #1;
            if (i == 0) begin
                pushExp(SC0, "cascade.reset0", 0, 1'b0, 1'b0);
                pushExp(SC1, "cascade.reset1", 0, 1'b0, 1'b0);
            end else begin
                o = observe(SC0);
                checks++;
                if (o.tc !== (en && cur0 == 9)) begin
                    errors++;
                    $display("[TB] FAIL cascade tc0 step%0d: got %b expected %b", i, o.tc, (en && cur0 == 9));
                end
                if (en) begin
                    pushExp(SC0, $sformatf("cascade0.step%0d", i), (cur0 + 1) % 10, 1'b0, cur0 == 9);
                    pushExp(SC1, $sformatf("cascade1.step%0d", i), (cur0 == 9) ? (cur1 + 1) % 10 : cur1,
                            1'b0, (cur0 == 9) && (cur1 == 9));
                end else begin
                    pushExp(SC0, $sformatf("cascade0.hold%0d", i), 7, 1'b0, 1'b0);
                    pushExp(SC1, $sformatf("cascade1.hold%0d", i), 3, 1'b0, 1'b0);
                end
            end
            @(posedge clock); #1;
            while (sbQ.size() != 0) begin
                e = sbQ.pop_front();
                o = observe(e.sel);
                checks++;
                if (o.q !== 32'(e.q)) begin errors++; $display("[TB] FAIL %s q: got %0d expected %0d", e.tag, o.q, e.q); end
                checks++;
                if (o.dir !== e.dir) begin errors++; $display("[TB] FAIL %s dir: got %b expected %b", e.tag, o.dir, e.dir); end
                checks++;
                if (o.wrap !== e.wrap) begin errors++; $display("[TB] FAIL %s wrap: got %b expected %b", e.tag, o.wrap, e.wrap); end
            end
            if (i == 37) begin
                checks++;
                if (qC0 !== 4'd7 || qC1 !== 4'd3) begin
                    errors++;
                    $display("[TB] FAIL cascade_after_37: got %0d/%0d expected 7/3", qC0, qC1);
                end
            end
        end
    endtask

    initial begin
        rstN  = 1'b0;
        en    = 1'b0;
        loadN = 1'b1;
        mode  = MODE_HOLD;
        d10   = 4'd0;
        d4    = 2'd0;
        d2    = 2'd0;
        dFull = 8'd0;
        dCas  = 4'd0;
        test_reset();
        test_up_wrap();
        test_down_load();
        test_hold();
        test_pingpong();
        test_mode_change();
        test_priority();
        test_full_width();
        test_cascade();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
